// File: rtl/ff_bank_ctrl_if.sv
// Command/status bundle between a command source and the flip-flop bank sequencer.
// The master side issues start/op/din/count/sin; the slave side reports busy/done
// and exposes the bank contents in true, complemented and serial form.
interface ff_bank_ctrl_if #(
    parameter int WIDTH = 8,
    parameter int CNTW  = 4
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] din;
    logic [CNTW-1:0]  count;
    logic             sin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] qnegado;
    logic             sout;

    modport master (
        output start, op, din, count, sin,
        input  busy, done, q, qnegado, sout
    );

    modport slave (
        input  start, op, din, count, sin,
        output busy, done, q, qnegado, sout
    );
endinterface

// File: rtl/ff_bank_ctrl.sv
// Sequencer for a WIDTH-bit D flip-flop bank with complementary outputs.
// One command (LOAD, SHIFT, PRESET, CLEAR) is accepted per start/busy/done
// handshake; op, din and count are captured at the accepting edge so later
// changes on the bus cannot disturb a running command.
module ff_bank_ctrl #(
    parameter int WIDTH = 8,
    parameter int CNTW  = 4
) (
    input  logic          clk,
    input  logic          clr,
    ff_bank_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        EXEC  = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [1:0] OP_LOAD   = 2'b00;
    localparam logic [1:0] OP_SHIFT  = 2'b01;
    localparam logic [1:0] OP_PRESET = 2'b10;
    localparam logic [1:0] OP_CLEAR  = 2'b11;

    state_t           state_q, state_d;
    logic [1:0]       op_q, op_d;
    logic [WIDTH-1:0] din_q, din_d;
    logic [WIDTH-1:0] bank_q, bank_d;
    logic [CNTW-1:0]  remaining_q, remaining_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    // Next-state logic: everything holds unless the current state explicitly updates it.
    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        din_d       = din_q;
        bank_d      = bank_q;
        remaining_d = remaining_q;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    op_d        = bus.op;
                    din_d       = bus.din;
                    remaining_d = bus.count;
                    state_d     = (bus.op == OP_SHIFT) ? SHIFT : EXEC;
                end
            end
            EXEC: begin
                case (op_q)
                    OP_LOAD:   bank_d = din_q;
                    OP_PRESET: bank_d = '1;
                    OP_CLEAR:  bank_d = '0;
                    default:   bank_d = bank_q;
                endcase
                state_d = DONE;
            end
            SHIFT: begin
                if (remaining_q != '0) begin
                    bank_d      = {bank_q[WIDTH-2:0], bus.sin};
                    remaining_d = remaining_q - CNTW'(1);
                    if (remaining_q == CNTW'(1)) begin
                        state_d = DONE;
                    end
                end else begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d == EXEC) || (state_d == SHIFT);
        done_d = (state_d == DONE);
    end

    // State, bank and handshake registers; clr wins over any command in flight.
    always_ff @(posedge clk) begin
        if (clr) begin
            state_q     <= IDLE;
            op_q        <= '0;
            din_q       <= '0;
            bank_q      <= '0;
            remaining_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            din_q       <= din_d;
            bank_q      <= bank_d;
            remaining_q <= remaining_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign bus.q       = bank_q;
    assign bus.qnegado = ~bank_q;
    assign bus.sout    = bank_q[WIDTH-1];
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;

endmodule

// File: tb/tb_ff_bank_ctrl.sv
// Self-checking bench for ff_bank_ctrl: a cycle-level behavioural model of the
// command protocol is compared against the DUT on every falling edge, and
// directed sequences pin known bank values at hand-picked cycles.
module tb_ff_bank_ctrl;

    localparam int WIDTH = 8;
    localparam int CNTW  = 4;

    logic clk;
    logic clr;
    int   checks;
    int   passes;

    ff_bank_ctrl_if #(.WIDTH(WIDTH), .CNTW(CNTW)) bus ();

    ff_bank_ctrl #(.WIDTH(WIDTH), .CNTW(CNTW)) dut (
        .clk (clk),
        .clr (clr),
        .bus (bus)
    );

    // Free-running clock, 10 time units per cycle.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Behavioural model: a command is a busy phase of a known length followed
    // by a single done cycle; shifts are plain arithmetic on an integer.
    int m_q;
    int m_busy;
    int m_done;
    int m_kind;
    int m_steps;
    int m_din;

    initial begin
        m_q = 0; m_busy = 0; m_done = 0; m_kind = 0; m_steps = 0; m_din = 0;
    end

    // Advance the model on each rising edge from the inputs seen at that edge.
    always @(posedge clk) begin
        if (clr) begin
            m_q = 0; m_busy = 0; m_done = 0;
        end else if (m_done != 0) begin
            m_done = 0;
        end else if (m_busy != 0) begin
            if (m_kind == 1) begin
                if (m_steps > 0) begin
                    m_q     = (m_q * 2 + int'(bus.sin)) % 256;
                    m_steps = m_steps - 1;
                end
                if (m_steps == 0) begin
                    m_busy = 0; m_done = 1;
                end
            end else begin
                if (m_kind == 0)      m_q = m_din;
                else if (m_kind == 2) m_q = 255;
                else                  m_q = 0;
                m_busy = 0; m_done = 1;
            end
        end else if (bus.start) begin
            m_busy  = 1;
            m_kind  = int'(bus.op);
            m_steps = int'(bus.count);
            m_din   = int'(bus.din);
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) begin
            passes++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Compare every observable output against the model once per cycle.
    always @(negedge clk) begin
        checkOutput("cyc_q",    32'(bus.q),       32'(m_q));
        checkOutput("cyc_qn",   32'(bus.qnegado), 32'((~m_q) & 255));
        checkOutput("cyc_sout", 32'(bus.sout),    32'((m_q >> 7) & 1));
        checkOutput("cyc_busy", 32'(bus.busy),    32'(m_busy));
        checkOutput("cyc_done", 32'(bus.done),    32'(m_done));
    end

    task automatic applyStimulus(input logic s, input logic [1:0] o, input logic [7:0] d,
                                 input logic [3:0] c, input logic si);
        bus.start = s;
        bus.op    = o;
        bus.din   = d;
        bus.count = c;
        bus.sin   = si;
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic waitDone(input int limit);
        int n;
        n = 0;
        while (bus.done !== 1'b1 && n < limit) begin
            step();
            n++;
        end
        checkOutput("done_wait", 32'(bus.done), 32'd1);
    endtask

    // Directed command sequences with literal expectations.
    initial begin
        checks = 0;
        passes = 0;
        clr = 1'b1;
        applyStimulus(1'b1, 2'b00, 8'h3C, 4'd0, 1'b0);
        step();
        step();
        checkOutput("rst_q",    32'(bus.q),       32'h00);
        checkOutput("rst_qn",   32'(bus.qnegado), 32'hFF);
        checkOutput("rst_busy", 32'(bus.busy),    32'd0);
        checkOutput("rst_done", 32'(bus.done),    32'd0);
        clr = 1'b0;
        applyStimulus(1'b0, 2'b00, 8'h3C, 4'd0, 1'b0);
        step();
        step();
        checkOutput("idle_q",    32'(bus.q),    32'h00);
        checkOutput("idle_busy", 32'(bus.busy), 32'd0);

        $display("[TB] LOAD 0xA5");
        applyStimulus(1'b1, 2'b00, 8'hA5, 4'd0, 1'b0);
        step();
        applyStimulus(1'b0, 2'b00, 8'hA5, 4'd0, 1'b0);
        checkOutput("load_e0_busy", 32'(bus.busy), 32'd1);
        checkOutput("load_e0_q",    32'(bus.q),    32'h00);
        step();
        checkOutput("load_e1_q",    32'(bus.q),       32'hA5);
        checkOutput("load_e1_qn",   32'(bus.qnegado), 32'h5A);
        checkOutput("load_e1_done", 32'(bus.done),    32'd1);
        checkOutput("load_e1_busy", 32'(bus.busy),    32'd0);
        step();
        checkOutput("load_e2_done", 32'(bus.done), 32'd0);

        $display("[TB] PRESET then CLEAR");
        applyStimulus(1'b1, 2'b10, 8'h00, 4'd0, 1'b0);
        step();
        applyStimulus(1'b0, 2'b10, 8'h00, 4'd0, 1'b0);
        waitDone(4);
        checkOutput("preset_q", 32'(bus.q), 32'hFF);
        step();
        applyStimulus(1'b1, 2'b11, 8'h00, 4'd0, 1'b0);
        step();
        applyStimulus(1'b0, 2'b11, 8'h00, 4'd0, 1'b0);
        waitDone(4);
        checkOutput("clear_q", 32'(bus.q), 32'h00);
        step();

        $display("[TB] SHIFT count=3 sin=1 from 0x81");
        applyStimulus(1'b1, 2'b00, 8'h81, 4'd0, 1'b0);
        step();
        applyStimulus(1'b0, 2'b00, 8'h81, 4'd0, 1'b0);
        waitDone(4);
        checkOutput("load81_q", 32'(bus.q), 32'h81);
        step();
        applyStimulus(1'b1, 2'b01, 8'h00, 4'd3, 1'b1);
        step();
        applyStimulus(1'b0, 2'b01, 8'h00, 4'd3, 1'b1);
        checkOutput("sh3_e0_q",    32'(bus.q),    32'h81);
        checkOutput("sh3_e0_busy", 32'(bus.busy), 32'd1);
        step();
        checkOutput("sh3_e1_q", 32'(bus.q), 32'h03);
        step();
        checkOutput("sh3_e2_q", 32'(bus.q), 32'h07);
        step();
        checkOutput("sh3_e3_q",    32'(bus.q),    32'h0F);
        checkOutput("sh3_e3_done", 32'(bus.done), 32'd1);
        checkOutput("sh3_e3_sout", 32'(bus.sout), 32'd0);
        step();

        $display("[TB] SHIFT count=0");
        applyStimulus(1'b1, 2'b01, 8'h00, 4'd0, 1'b1);
        step();
        applyStimulus(1'b0, 2'b01, 8'h00, 4'd0, 1'b1);
        checkOutput("sh0_e0_busy", 32'(bus.busy), 32'd1);
        step();
        checkOutput("sh0_e1_done", 32'(bus.done), 32'd1);
        checkOutput("sh0_e1_q",    32'(bus.q),    32'h0F);
        step();

        $display("[TB] start held through a count=5 shift");
        applyStimulus(1'b1, 2'b01, 8'h11, 4'd5, 1'b0);
        step();
        applyStimulus(1'b1, 2'b00, 8'h77, 4'd5, 1'b0);
        checkOutput("hold_e0_busy", 32'(bus.busy), 32'd1);
        step();
        checkOutput("hold_e1_q", 32'(bus.q), 32'h1E);
        step();
        checkOutput("hold_e2_q", 32'(bus.q), 32'h3C);
        step();
        checkOutput("hold_e3_q", 32'(bus.q), 32'h78);
        step();
        checkOutput("hold_e4_q", 32'(bus.q), 32'hF0);
        step();
        checkOutput("hold_e5_q",    32'(bus.q),    32'hE0);
        checkOutput("hold_e5_done", 32'(bus.done), 32'd1);
        step();
        checkOutput("hold_e6_busy", 32'(bus.busy), 32'd0);
        checkOutput("hold_e6_done", 32'(bus.done), 32'd0);
        step();
        checkOutput("hold_e7_busy", 32'(bus.busy), 32'd1);
        checkOutput("hold_e7_q",    32'(bus.q),    32'hE0);
        applyStimulus(1'b0, 2'b00, 8'h77, 4'd0, 1'b0);
        step();
        checkOutput("hold_e8_q",    32'(bus.q),    32'h77);
        checkOutput("hold_e8_done", 32'(bus.done), 32'd1);
        step();

        $display("[TB] clr at third edge of a count=6 shift");
        applyStimulus(1'b1, 2'b01, 8'h00, 4'd6, 1'b1);
        step();
        applyStimulus(1'b0, 2'b01, 8'h00, 4'd6, 1'b1);
        step();
        checkOutput("abort_e1_q", 32'(bus.q), 32'hEF);
        step();
        checkOutput("abort_e2_q", 32'(bus.q), 32'hDF);
        clr = 1'b1;
        step();
        clr = 1'b0;
        checkOutput("abort_q",    32'(bus.q),       32'h00);
        checkOutput("abort_qn",   32'(bus.qnegado), 32'hFF);
        checkOutput("abort_busy", 32'(bus.busy),    32'd0);
        checkOutput("abort_done", 32'(bus.done),    32'd0);
        step();
        checkOutput("abort_nodone", 32'(bus.done), 32'd0);
        applyStimulus(1'b1, 2'b00, 8'h5C, 4'd0, 1'b0);
        step();
        applyStimulus(1'b0, 2'b00, 8'h5C, 4'd0, 1'b0);
        waitDone(4);
        checkOutput("after_abort_q", 32'(bus.q), 32'h5C);
        step();
        step();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
